// File: rtl/rs_age_issue_queue_if.sv
// Dispatch, CDB broadcast and issue signal bundle of the age-ordered reservation station.
// master = dispatch/CDB/FU side, slave = the station itself.
interface rs_age_issue_queue_if #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROBEN_W = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CDB = 2
);
  localparam int unsigned ID_W = $clog2(DEPTH) + 1;

  logic                       disp_valid;
  logic                       disp_ready;
  logic [11:0]                disp_opcode;
  logic [3:0]                 disp_aluop;
  logic [ROBEN_W-1:0]         disp_roben;
  logic [ROBEN_W-1:0]         disp_q1;
  logic [ROBEN_W-1:0]         disp_q2;
  logic [DATA_W-1:0]          disp_v1;
  logic [DATA_W-1:0]          disp_v2;
  logic [DATA_W-1:0]          disp_imm;

  logic [NUM_CDB*ROBEN_W-1:0] cdb_roben;
  logic [NUM_CDB*DATA_W-1:0]  cdb_val;

  logic                       iss_valid;
  logic                       iss_ready;
  logic [11:0]                iss_opcode;
  logic [3:0]                 iss_aluop;
  logic [ROBEN_W-1:0]         iss_roben;
  logic [DATA_W-1:0]          iss_val1;
  logic [DATA_W-1:0]          iss_val2;
  logic [DATA_W-1:0]          iss_imm;
  logic [ID_W-1:0]            iss_rs_id;

  modport master (
    output disp_valid, disp_opcode, disp_aluop, disp_roben, disp_q1, disp_q2,
           disp_v1, disp_v2, disp_imm, cdb_roben, cdb_val, iss_ready,
    input  disp_ready, iss_valid, iss_opcode, iss_aluop, iss_roben,
           iss_val1, iss_val2, iss_imm, iss_rs_id
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_aluop, disp_roben, disp_q1, disp_q2,
           disp_v1, disp_v2, disp_imm, cdb_roben, cdb_val, iss_ready,
    output disp_ready, iss_valid, iss_opcode, iss_aluop, iss_roben,
           iss_val1, iss_val2, iss_imm, iss_rs_id
  );
endinterface

// File: rtl/rs_age_issue_queue.sv
// Reservation station: tag-based CDB wakeup with dispatch bypass, oldest-ready-first issue
// chosen through an age matrix; an entry is released only on the FU handshake.
module rs_age_issue_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROBEN_W = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  rs_age_issue_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] free_count
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TV_W  = ROBEN_W + DATA_W;

  logic [DEPTH-1:0]   busy;
  logic [11:0]        opcode_q [DEPTH];
  logic [3:0]         aluop_q  [DEPTH];
  logic [ROBEN_W-1:0] roben_q  [DEPTH];
  logic [ROBEN_W-1:0] q1_q     [DEPTH];
  logic [ROBEN_W-1:0] q2_q     [DEPTH];
  logic [DATA_W-1:0]  v1_q     [DEPTH];
  logic [DATA_W-1:0]  v2_q     [DEPTH];
  logic [DATA_W-1:0]  imm_q    [DEPTH];
  // age[i][j] set: entry i was accepted before entry j
  logic [DEPTH-1:0]   age      [DEPTH];

  logic [ROBEN_W-1:0] q1_w [DEPTH];
  logic [ROBEN_W-1:0] q2_w [DEPTH];
  logic [DATA_W-1:0]  v1_w [DEPTH];
  logic [DATA_W-1:0]  v2_w [DEPTH];
  logic [ROBEN_W-1:0] dq1_c, dq2_c;
  logic [DATA_W-1:0]  dv1_c, dv2_c;

  logic [DEPTH-1:0]   ready_c;
  logic [DEPTH-1:0]   older_c [DEPTH];
  logic [IDX_W-1:0]   free_idx_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic               have_sel_c;
  logic               disp_ready_c;
  logic               iss_valid_c;
  logic               accept_c;
  logic               issue_c;

  // Resolve one source operand against all CDB channels; the lowest matching channel wins.
  function automatic logic [TV_W-1:0] snoop(
    input logic [ROBEN_W-1:0]         tag,
    input logic [DATA_W-1:0]          val,
    input logic [NUM_CDB*ROBEN_W-1:0] ctag,
    input logic [NUM_CDB*DATA_W-1:0]  cval
  );
    logic [TV_W-1:0] res;
    res = {tag, val};
    if (tag != '0) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (ctag[c*ROBEN_W +: ROBEN_W] == tag) begin
          res = {ROBEN_W'(0), cval[c*DATA_W +: DATA_W]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {q1_w[i], v1_w[i]} = snoop(q1_q[i], v1_q[i], bus.cdb_roben, bus.cdb_val);
      {q2_w[i], v2_w[i]} = snoop(q2_q[i], v2_q[i], bus.cdb_roben, bus.cdb_val);
    end
    {dq1_c, dv1_c} = snoop(bus.disp_q1, bus.disp_v1, bus.cdb_roben, bus.cdb_val);
    {dq2_c, dv2_c} = snoop(bus.disp_q2, bus.disp_v2, bus.cdb_roben, bus.cdb_val);
  end

  // Ready vector and the transposed age matrix (older_c[i][j]: j is older than i).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_c[i] = busy[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
      for (int j = 0; j < DEPTH; j++) begin
        older_c[i][j] = age[j][i];
      end
    end
  end

  // Lowest-index free slot.
  always_comb begin
    free_idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx_c = IDX_W'(i);
      end
    end
  end

  // Oldest ready entry: ready with no older ready entry.
  always_comb begin
    sel_idx_c  = '0;
    have_sel_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_c[i] && ((ready_c & older_c[i]) == '0)) begin
        sel_idx_c  = IDX_W'(i);
        have_sel_c = 1'b1;
      end
    end
  end

  assign disp_ready_c = ~&busy;
  assign iss_valid_c  = have_sel_c & ~flush;
  assign accept_c     = bus.disp_valid & disp_ready_c & ~flush;
  assign issue_c      = iss_valid_c & bus.iss_ready;

  assign bus.disp_ready = disp_ready_c;

  // Issue payload; zeroed whenever nothing is presented.
  always_comb begin
    bus.iss_valid  = iss_valid_c;
    bus.iss_opcode = '0;
    bus.iss_aluop  = '0;
    bus.iss_roben  = '0;
    bus.iss_val1   = '0;
    bus.iss_val2   = '0;
    bus.iss_imm    = '0;
    bus.iss_rs_id  = '0;
    if (iss_valid_c) begin
      bus.iss_opcode = opcode_q[sel_idx_c];
      bus.iss_aluop  = aluop_q[sel_idx_c];
      bus.iss_roben  = roben_q[sel_idx_c];
      bus.iss_val1   = v1_q[sel_idx_c];
      bus.iss_val2   = v2_q[sel_idx_c];
      bus.iss_imm    = imm_q[sel_idx_c];
      bus.iss_rs_id  = CNT_W'(sel_idx_c) + CNT_W'(1);
    end
  end

  // Entry storage, age matrix and free counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      free_count <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0;
        aluop_q[i]  <= '0;
        roben_q[i]  <= '0;
        q1_q[i]     <= '0;
        q2_q[i]     <= '0;
        v1_q[i]     <= '0;
        v2_q[i]     <= '0;
        imm_q[i]    <= '0;
        age[i]      <= '0;
      end
    end else if (flush) begin
      busy       <= '0;
      free_count <= CNT_W'(DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          q1_q[i] <= q1_w[i];
          q2_q[i] <= q2_w[i];
          v1_q[i] <= v1_w[i];
          v2_q[i] <= v2_w[i];
        end
      end

      if (issue_c) begin
        busy[sel_idx_c] <= 1'b0;
      end

      // New entry becomes younger than every other slot; row write also clears the diagonal.
      if (accept_c) begin
        busy[free_idx_c]     <= 1'b1;
        opcode_q[free_idx_c] <= bus.disp_opcode;
        aluop_q[free_idx_c]  <= bus.disp_aluop;
        roben_q[free_idx_c]  <= bus.disp_roben;
        q1_q[free_idx_c]     <= dq1_c;
        q2_q[free_idx_c]     <= dq2_c;
        v1_q[free_idx_c]     <= dv1_c;
        v2_q[free_idx_c]     <= dv2_c;
        imm_q[free_idx_c]    <= bus.disp_imm;
        for (int j = 0; j < DEPTH; j++) begin
          age[j][free_idx_c] <= 1'b1;
        end
        age[free_idx_c] <= '0;
      end

      case ({accept_c, issue_c})
        2'b10:   free_count <= free_count - CNT_W'(1);
        2'b01:   free_count <= free_count + CNT_W'(1);
        default: free_count <= free_count;
      endcase
    end
  end
endmodule
